// File: rtl/switch_alloc_np.sv
// Router switch allocator: one round-robin arbiter per output, registered output flits,
// optional wormhole locking (PACKET_MODE=1) that holds an output from head flit to tail flit.
module switch_alloc_np #(
  parameter int NPORTS      = 5,
  parameter int DATASIZE    = 40,
  parameter int PACKET_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS*NPORTS-1:0]     in_label,
  input  logic [NPORTS*DATASIZE-1:0]   in_data,
  input  logic [NPORTS-1:0]            out_full,
  output logic [NPORTS-1:0]            in_ready,
  output logic [NPORTS-1:0]            out_valid,
  output logic [NPORTS*DATASIZE-1:0]   out_data
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [NPORTS-1:0] req_oh [NPORTS];
  logic [NPORTS-1:0] grant_valid;
  logic [PW-1:0]     win [NPORTS];

  genvar gi, gj;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_in
      logic [NPORTS-1:0] masked;
      // Drop the U-turn bit, then isolate the lowest remaining set bit.
      assign masked      = in_label[gi*NPORTS +: NPORTS] & ~(NPORTS'(1) << gi);
      assign req_oh[gi]  = masked & (~masked + NPORTS'(1));
    end

    for (gi = 0; gi < NPORTS; gi++) begin : g_out
      logic [NPORTS-1:0]   reqs;
      logic [NPORTS-1:0]   elig;
      logic [2*NPORTS-1:0] dbl;
      logic [NPORTS-1:0]   rot;
      logic [PW-1:0]       ptr_reg;
      logic [PW-1:0]       owner_reg;
      logic [PW-1:0]       pick;
      logic [PW-1:0]       ptr_next;
      logic                locked_reg;
      logic                valid_reg;
      logic                found;
      logic [DATASIZE-1:0] data_reg;
      logic [DATASIZE-1:0] win_data;

      for (gj = 0; gj < NPORTS; gj++) begin : g_col
        assign reqs[gj] = req_oh[gj][gi];
      end

      // While locked only the packet owner may compete for this output.
      assign elig = (PACKET_MODE != 0 && locked_reg) ? (reqs & (NPORTS'(1) << owner_reg)) : reqs;
      assign dbl  = {elig, elig} >> ptr_reg;
      assign rot  = dbl[NPORTS-1:0];

      always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NPORTS; k++) begin
          if (!found && rot[k]) begin
            found = 1'b1;
            pick  = PW'((int'(ptr_reg) + k) % NPORTS);
          end
        end
      end

      always_comb begin
        win_data = '0;
        for (int k = 0; k < NPORTS; k++) begin
          if (pick == PW'(k)) win_data = in_data[k*DATASIZE +: DATASIZE];
        end
      end

      assign grant_valid[gi] = found & ~out_full[gi] & ~rst;
      assign win[gi]         = pick;
      assign ptr_next        = (pick == PW'(NPORTS-1)) ? '0 : pick + 1'b1;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ptr_reg    <= '0;
          owner_reg  <= '0;
          locked_reg <= 1'b0;
          valid_reg  <= 1'b0;
          data_reg   <= '0;
        end else begin
          valid_reg <= grant_valid[gi];
          if (grant_valid[gi]) begin
            data_reg <= win_data;
            if (PACKET_MODE == 0) begin
              ptr_reg <= ptr_next;
            end else begin
              case (win_data[1:0])
                2'b01: begin
                  if (!locked_reg) begin
                    locked_reg <= 1'b1;
                    owner_reg  <= pick;
                  end
                end
                2'b10, 2'b11: begin
                  locked_reg <= 1'b0;
                  ptr_reg    <= ptr_next;
                end
                default: ;
              endcase
            end
          end
        end
      end

      assign out_valid[gi]                       = valid_reg;
      assign out_data[gi*DATASIZE +: DATASIZE]   = data_reg;
    end
  endgenerate

  // Each input targets exactly one output, so it can win at most one arbiter.
  always_comb begin
    in_ready = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (grant_valid[o] && win[o] == PW'(i)) in_ready[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_alloc_np.sv
// Bench for switch_alloc_np: a mode-0 and a mode-1 instance share stimulus and are checked
// every cycle against a behavioural allocator model, plus directed literal scenarios.
module tb_switch_alloc_np;
  localparam int N  = 5;
  localparam int DW = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*N-1:0]    in_label = '0;
  logic [N*DW-1:0]   in_data  = '0;
  logic [N-1:0]      out_full = '0;
  logic [N-1:0]      rdy0, rdy1, vld0, vld1;
  logic [N*DW-1:0]   dat0, dat1;

  switch_alloc_np #(.NPORTS(N), .DATASIZE(DW), .PACKET_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_label(in_label), .in_data(in_data), .out_full(out_full),
    .in_ready(rdy0), .out_valid(vld0), .out_data(dat0));

  switch_alloc_np #(.NPORTS(N), .DATASIZE(DW), .PACKET_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_label(in_label), .in_data(in_data), .out_full(out_full),
    .in_ready(rdy1), .out_valid(vld1), .out_data(dat1));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int            m_ptr   [2][N];
  bit            m_lock  [2][N];
  int            m_owner [2][N];
  bit            m_vld   [2][N];
  logic [DW-1:0] m_dat   [2][N];
  int            g_win   [2][N];

  logic [N-1:0]    s_rdy [2];
  logic [N-1:0]    s_vld [2];
  logic [N*DW-1:0] s_dat [2];

  task automatic chk(string nm, logic [N*DW-1:0] act, logic [N*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkflit(int i, logic [1:0] typ, logic [7:0] tag);
    return {4'(i), 4'h0, tag, 22'(tag) * 22'd3, typ};
  endfunction

  // Output an input is really heading for: lowest set bit that is not its own port.
  function automatic int target(int i);
    logic [N-1:0] l;
    l = in_label[i*N +: N];
    for (int b = 0; b < N; b++) if (b != i && l[b]) return b;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int o = 0; o < N; o++) begin
        m_ptr[m][o] = 0; m_lock[m][o] = 0; m_owner[m][o] = 0;
        m_vld[m][o] = 0; m_dat[m][o] = '0;
      end
  endtask

  task automatic model_grants();
    for (int m = 0; m < 2; m++)
      for (int o = 0; o < N; o++) begin
        g_win[m][o] = -1;
        if (!out_full[o]) begin
          if (m == 1 && m_lock[m][o]) begin
            if (target(m_owner[m][o]) == o) g_win[m][o] = m_owner[m][o];
          end else begin
            for (int k = 0; k < N; k++) begin
              int i;
              i = (m_ptr[m][o] + k) % N;
              if (g_win[m][o] < 0 && target(i) == o) g_win[m][o] = i;
            end
          end
        end
      end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++)
      for (int o = 0; o < N; o++) begin
        int w;
        w = g_win[m][o];
        m_vld[m][o] = (w >= 0);
        if (w >= 0) begin
          m_dat[m][o] = in_data[w*DW +: DW];
          if (m == 0) m_ptr[m][o] = (w + 1) % N;
          else if (m_dat[m][o][1:0] == 2'b01) begin
            if (!m_lock[m][o]) begin m_lock[m][o] = 1; m_owner[m][o] = w; end
          end else if (m_dat[m][o][1:0] != 2'b00) begin
            m_lock[m][o] = 0;
            m_ptr[m][o]  = (w + 1) % N;
          end
        end
      end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [N-1:0]    er, ev;
    logic [N*DW-1:0] ed;
    @(negedge clk);
    model_grants();
    s_rdy[0] = rdy0; s_vld[0] = vld0; s_dat[0] = dat0;
    s_rdy[1] = rdy1; s_vld[1] = vld1; s_dat[1] = dat1;
    for (int m = 0; m < 2; m++) begin
      er = '0; ev = '0; ed = '0;
      for (int o = 0; o < N; o++) begin
        if (g_win[m][o] >= 0) er[g_win[m][o]] = 1'b1;
        ev[o] = m_vld[m][o];
        ed[o*DW +: DW] = m_dat[m][o];
      end
      chk($sformatf("m%0d_in_ready", m), s_rdy[m], er);
      chk($sformatf("m%0d_out_valid", m), s_vld[m], ev);
      chk($sformatf("m%0d_out_data", m), s_dat[m], ed);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset(int cycles);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_valid0", vld0, '0);
    chk("rst_valid1", vld1, '0);
    chk("rst_data0", dat0, '0);
    chk("rst_data1", dat1, '0);
    chk("rst_ready0", rdy0, '0);
    chk("rst_ready1", rdy1, '0);
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_in(int i, logic [N-1:0] lab, logic [1:0] typ, logic [7:0] tag);
    in_label[i*N +: N]  = lab;
    in_data[i*DW +: DW] = mkflit(i, typ, tag);
  endtask

  task automatic clear_all();
    in_label = '0; in_data = '0; out_full = '0;
  endtask

  initial begin
    logic [N-1:0] seq [6];
    logic [1:0]   typs [4];
    seq  = '{5'b00010, 5'b00100, 5'b01000, 5'b00010, 5'b00100, 5'b01000};
    typs = '{2'b01, 2'b00, 2'b00, 2'b10};

    @(posedge clk); #1;
    clear_all();
    pulse_reset(2);

    // Three inputs contending for output 0 rotate 1,2,3,1,2,3.
    set_in(1, 5'b00001, 2'b11, 8'h11);
    set_in(2, 5'b00001, 2'b11, 8'h22);
    set_in(3, 5'b00001, 2'b11, 8'h33);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("r28_grant_m0", s_rdy[0], seq[k]);
      chk("r28_grant_m1", s_rdy[1], seq[k]);
      if (k >= 1) chk("r28_valid", s_vld[0][0], 1'b1);
      if (k == 1) chk("r28_data", s_dat[0][DW-1:0], mkflit(1, 2'b11, 8'h11));
    end

    // Backpressure on output 4.
    in_label = '0;
    set_in(2, 5'b10000, 2'b11, 8'h44);
    out_full = 5'b10000;
    repeat (3) begin step(); chk("r29_stall", s_rdy[0], 5'b00000); end
    out_full = '0;
    step(); chk("r29_release", s_rdy[0], 5'b00100);
    in_label = '0;
    step();
    chk("r29_valid", s_vld[0][4], 1'b1);
    chk("r29_data", s_dat[0][4*DW +: DW], mkflit(2, 2'b11, 8'h44));

    // Multi-hot label and U-turn label.
    in_label = '0;
    set_in(0, 5'b00011, 2'b11, 8'h55);
    set_in(3, 5'b01000, 2'b11, 8'h66);
    step(); chk("r31_grant", s_rdy[0], 5'b00001);
    step(); chk("r31_grant2", s_rdy[0], 5'b00001);
    chk("r31_valid", s_vld[0], 5'b00010);

    // Independent outputs in one cycle.
    in_label = '0;
    set_in(0, 5'b00010, 2'b11, 8'h70);
    set_in(2, 5'b01000, 2'b11, 8'h72);
    set_in(4, 5'b00001, 2'b11, 8'h74);
    step(); chk("r33_ready", s_rdy[0], 5'b10101);
    in_label = '0;
    step();
    chk("r33_valid", s_vld[0], 5'b01011);
    chk("r33_data1", s_dat[0][1*DW +: DW], mkflit(0, 2'b11, 8'h70));
    chk("r33_data3", s_dat[0][3*DW +: DW], mkflit(2, 2'b11, 8'h72));
    chk("r33_data0", s_dat[0][0*DW +: DW], mkflit(4, 2'b11, 8'h74));

    // Wormhole: input 1 keeps output 3 for a whole packet while input 4 waits.
    clear_all();
    pulse_reset(1);
    set_in(4, 5'b01000, 2'b01, 8'h90);
    for (int k = 0; k < 4; k++) begin
      set_in(1, 5'b01000, typs[k], 8'h81 + 8'(k));
      step();
      chk("r30_owner", s_rdy[1], 5'b00010);
    end
    set_in(1, 5'b00000, 2'b00, 8'h00);
    step(); chk("r30_next", s_rdy[1], 5'b10000);

    // Reset in the middle of a locked packet.
    clear_all();
    pulse_reset(1);
    set_in(1, 5'b01000, 2'b01, 8'hA1);
    step(); chk("r32_head", s_rdy[1], 5'b00010);
    set_in(1, 5'b01000, 2'b00, 8'hA2);
    step();
    pulse_reset(2);
    set_in(1, 5'b00000, 2'b00, 8'hA3);
    set_in(4, 5'b01000, 2'b01, 8'hB4);
    step(); chk("r32_new_head", s_rdy[1], 5'b10000);

    // Randomised traffic.
    clear_all();
    pulse_reset(1);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        in_label[i*N +: N]  = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom_range(1, 31));
        in_data[i*DW +: DW] = {8'($urandom), 32'($urandom)};
        out_full[i]         = ($urandom_range(0, 3) == 0);
      end
      if (c == 400) pulse_reset(1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_alloc_np.md
SWITCH_ALLOC_NP -- requirements
Module: switch_alloc_np

Interface
REQ-001 Parameter NPORTS, default 5; router port count; port 0 is Local, ports 1..NPORTS-1 are mesh directions.
REQ-002 Parameter DATASIZE, default 40; flit width: src 4b, dst 4b, timestamp 8b, data 22b, type 2b in bits [1:0].
REQ-003 Parameter PACKET_MODE, default 0; 0 = per-flit arbitration, 1 = wormhole output locking from head flit to tail flit.
REQ-004 Port clk, input, 1; single clock; all state on rising edge.
REQ-005 Port rst, input, 1; asynchronous, active-high reset.
REQ-006 Port in_label, input, NPORTS*NPORTS; field i is the one-hot destination request of input i; all-zero means no request.
REQ-007 Port in_data, input, NPORTS*DATASIZE; field i is the head flit of input i's buffer.
REQ-008 Port out_full, input, NPORTS; bit o high means downstream of output o cannot accept a flit.
REQ-009 Port in_ready, output, NPORTS; bit i high means input i's flit is taken this cycle (pop strobe).
REQ-010 Port out_valid, output, NPORTS; bit o high means out_data field o carries a valid flit.
REQ-011 Port out_data, output, NPORTS*DATASIZE; registered output flits.

Function
REQ-012 Effective request: input i requests output o when in_label field i bit o is 1, o != i (U-turn bits ignored), and o is the lowest set bit among the non-U-turn bits (multi-hot labels resolve to lowest index).
REQ-013 Each output o has a round-robin arbiter with pointer ptr[o] (width clog2(NPORTS)); the winner is the first requesting input at index ptr[o], ptr[o]+1, ... modulo NPORTS.
REQ-014 Output o grants only when out_full[o]=0; when out_full[o]=1 no input is granted to o and ptr[o] is unchanged.
REQ-015 in_ready[i] is combinational and equals 1 exactly when input i is granted by its requested output this cycle; an input is never granted by more than one output.
REQ-016 On a grant of input i to output o, the next rising edge loads out_data field o with in_data field i and sets out_valid[o]=1; latency is one cycle.
REQ-017 out_valid[o] is 0 in any cycle following a cycle with no grant at o; out_data field o holds its last value when not loaded.
REQ-018 PACKET_MODE=0: after a grant to input w, ptr[o] becomes (w+1) mod NPORTS.
REQ-019 PACKET_MODE=1: output o has states IDLE and LOCKED(owner); a granted head flit (type 2'b01) moves o to LOCKED with owner=winner; a single-flit packet (type 2'b11) leaves o IDLE.
REQ-020 In LOCKED, only the owner is eligible at o; other requesters stall with in_ready=0 regardless of pointer.
REQ-021 In LOCKED, a transferred tail flit (type 2'b10) returns o to IDLE at the next edge and sets ptr[o]=(owner+1) mod NPORTS; body flits (2'b00) keep the lock and ptr[o].
REQ-022 In LOCKED with out_full[o]=1 or the owner not requesting, the lock holds and nothing transfers.
REQ-023 In PACKET_MODE=1, ptr[o] updates only on single-flit or tail transfers.
REQ-024 Simultaneous requests to different outputs are granted in the same cycle independently; throughput is one flit per output per cycle.

Reset
REQ-025 While rst=1: out_valid=0, out_data=0, all ptr=0, all outputs IDLE, in_ready=0 (combinationally forced).
REQ-026 Reset asserted mid-packet clears locks immediately; the partial packet is abandoned, no further flits of it are output, and it is not replayed.
REQ-027 The first grant may occur in the first cycle after rst deasserts.

Verification
REQ-028 NPORTS=5, mode 0: inputs 1,2,3 all request output 0 every cycle, out_full=0 -> grants 1,2,3,1,2,3 on consecutive cycles; out_valid[0] high continuously from cycle 2.
REQ-029 Input 2 requests output 4 with out_full[4]=1 for 3 cycles, then 0 -> in_ready[2]=0 for 3 cycles, then 1; flit appears on out_data field 4 one cycle later.
REQ-030 Mode 1: input 1 sends head/body/body/tail to output 3 while input 4 also requests output 3 -> four flits from input 1 contiguous, input 4 granted in the cycle after the tail transfer.
REQ-031 Input 0 label 5'b00011 -> treated as request to output 1; input 3 label 5'b01000 (U-turn) -> never granted, in_ready[3]=0.
REQ-032 Mode 1, rst pulsed between body flits of a locked packet -> outputs zero immediately, ptr=0, a new head from another input is granted the first cycle after release.
REQ-033 Inputs 0->1, 2->3, 4->0 simultaneously -> all three in_ready high in the same cycle; three out_valid bits high next cycle with matching data.
